// File: rtl/bgd_mul_pipe_sat_if.sv
// Stream bundle for bgd_mul_pipe_sat: operand side and result side,
// each with a valid/ready pair.
interface bgd_mul_pipe_sat_if #(
  parameter int A_WIDTH = 15,
  parameter int B_WIDTH = 15,
  parameter int P_WIDTH = 15
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] din0;
  logic [B_WIDTH-1:0] din1;
  logic               out_valid;
  logic               out_ready;
  logic [P_WIDTH-1:0] dout;
  logic               sat;

  modport master (
    output in_valid,
    output din0,
    output din1,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dout,
    input  sat
  );

  modport slave (
    input  in_valid,
    input  din0,
    input  din1,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dout,
    output sat
  );
endinterface

// File: rtl/bgd_mul_pipe_sat.sv
// Pipelined signed multiplier with fixed-point rescale, rounding,
// optional saturation, global-stall flow control and a sat counter.
module bgd_mul_pipe_sat #(
  parameter int A_WIDTH    = 15,
  parameter int B_WIDTH    = 15,
  parameter int P_WIDTH    = 15,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND_EN   = 0,
  parameter int SAT_EN     = 1,
  parameter int NUM_STAGE  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bgd_mul_pipe_sat_if.slave    bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] sat_cnt
);

  localparam int M   = A_WIDTH + B_WIDTH;
  localparam int E   = M + 1;
  localparam int D   = NUM_STAGE - 3;
  localparam int RSH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

  localparam logic signed [E-1:0] RND_K =
    ((ROUND_EN != 0) && (FRAC_SHIFT > 0)) ? (E'(1) << RSH) : '0;

  localparam logic signed [E-1:0] MAXV =
    {{(E-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [E-1:0] MINV =
    {{(E-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

  logic                        w_stall;
  logic                        w_acc;
  logic                        w_xout;

  logic signed [A_WIDTH-1:0]   r_a;
  logic signed [B_WIDTH-1:0]   r_b;
  logic                        r_v1;

  logic signed [M-1:0]         w_ax;
  logic signed [M-1:0]         w_bx;
  logic signed [M-1:0]         w_prod;
  logic signed [M-1:0]         r_p;
  logic                        r_v2;

  logic signed [E-1:0]         w_ext;
  logic signed [E-1:0]         w_rnd;
  logic signed [E-1:0]         w_sc;
  logic                        w_hi;
  logic                        w_lo;
  logic        [P_WIDTH-1:0]   w_res;
  logic                        w_sat;

  logic        [P_WIDTH-1:0]   r_d3;
  logic                        r_s3;
  logic                        r_v3;

  logic        [P_WIDTH-1:0]   w_dout;
  logic                        w_osat;
  logic                        w_ov;

  logic        [CNT_WIDTH-1:0] r_cnt;

  assign w_stall      = w_ov & ~bus.out_ready;
  assign w_acc        = bus.in_valid & ~w_stall;
  assign w_xout       = w_ov & bus.out_ready;

  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = w_ov;
  assign bus.dout      = w_dout;
  assign bus.sat       = w_osat;
  assign sat_cnt       = r_cnt;

  // Operands sign-extended to the full product width.
  assign w_ax   = {{B_WIDTH{r_a[A_WIDTH-1]}}, r_a};
  assign w_bx   = {{A_WIDTH{r_b[B_WIDTH-1]}}, r_b};
  assign w_prod = w_ax * w_bx;

  // One guard bit so the rounding add never overflows.
  assign w_ext  = {r_p[M-1], r_p};
  assign w_rnd  = w_ext + RND_K;
  assign w_sc   = w_rnd >>> FRAC_SHIFT;
  assign w_hi   = (w_sc > MAXV);
  assign w_lo   = (w_sc < MINV);

  always_comb begin
    w_res = w_sc[P_WIDTH-1:0];
    w_sat = 1'b0;
    if (SAT_EN != 0) begin
      unique case (1'b1)
        w_hi: begin
          w_res = MAXV[P_WIDTH-1:0];
          w_sat = 1'b1;
        end
        w_lo: begin
          w_res = MINV[P_WIDTH-1:0];
          w_sat = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_v1 <= 1'b0;
      r_p  <= '0;
      r_v2 <= 1'b0;
      r_d3 <= '0;
      r_s3 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (!w_stall) begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_a <= bus.din0;
        r_b <= bus.din1;
      end
      r_p  <= w_prod;
      r_v2 <= r_v1;
      r_d3 <= w_res;
      r_s3 <= w_sat;
      r_v3 <= r_v2;
    end
  end

  if (D > 0) begin : g_dly
    logic [P_WIDTH+1:0] r_q [D];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < D; i++) begin
          r_q[i] <= '0;
        end
      end else if (!w_stall) begin
        r_q[0] <= {r_v3, r_s3, r_d3};
        for (int i = 1; i < D; i++) begin
          r_q[i] <= r_q[i-1];
        end
      end
    end

    assign w_ov   = r_q[D-1][P_WIDTH+1];
    assign w_osat = r_q[D-1][P_WIDTH];
    assign w_dout = r_q[D-1][P_WIDTH-1:0];
  end else begin : g_nodly
    assign w_ov   = r_v3;
    assign w_osat = r_s3;
    assign w_dout = r_d3;
  end

  // Clear has priority; count sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_xout && w_osat && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_bgd_mul_pipe_sat.sv
// Bench for bgd_mul_pipe_sat: four configurations share one stimulus
// stream; a scoreboard checks every delivered result in order.
module tb_bgd_mul_pipe_sat;

  typedef struct {
    int a;
    int b;
    int e_d;
    bit s_d;
    int e_w;
    int e_1;
    bit s_1;
    int e_0;
    bit s_0;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [14:0] din0;
  logic [14:0] din1;
  logic        out_ready;
  logic        cnt_clr;
  logic [15:0] cd;
  logic [15:0] cw;
  logic [1:0]  c1;
  logic [1:0]  c0;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t cur;
  vec_t tbl[13];

  bgd_mul_pipe_sat_if #(.A_WIDTH(15), .B_WIDTH(15), .P_WIDTH(15)) ifd ();
  bgd_mul_pipe_sat_if #(.A_WIDTH(15), .B_WIDTH(15), .P_WIDTH(15)) ifw ();
  bgd_mul_pipe_sat_if #(.A_WIDTH(15), .B_WIDTH(15), .P_WIDTH(15)) if1 ();
  bgd_mul_pipe_sat_if #(.A_WIDTH(15), .B_WIDTH(15), .P_WIDTH(15)) if0 ();

  assign ifd.in_valid = in_valid;
  assign ifd.din0 = din0;
  assign ifd.din1 = din1;
  assign ifd.out_ready = out_ready;
  assign ifw.in_valid = in_valid;
  assign ifw.din0 = din0;
  assign ifw.din1 = din1;
  assign ifw.out_ready = out_ready;
  assign if1.in_valid = in_valid;
  assign if1.din0 = din0;
  assign if1.din1 = din1;
  assign if1.out_ready = out_ready;
  assign if0.in_valid = in_valid;
  assign if0.din0 = din0;
  assign if0.din1 = din1;
  assign if0.out_ready = out_ready;

  bgd_mul_pipe_sat ud (
    .clk(clk), .reset(reset), .bus(ifd), .cnt_clr(cnt_clr), .sat_cnt(cd)
  );

  bgd_mul_pipe_sat #(.SAT_EN(0)) uw (
    .clk(clk), .reset(reset), .bus(ifw), .cnt_clr(cnt_clr), .sat_cnt(cw)
  );

  bgd_mul_pipe_sat #(.FRAC_SHIFT(4), .ROUND_EN(1), .CNT_WIDTH(2)) u1 (
    .clk(clk), .reset(reset), .bus(if1), .cnt_clr(cnt_clr), .sat_cnt(c1)
  );

  bgd_mul_pipe_sat #(.FRAC_SHIFT(4), .ROUND_EN(0), .CNT_WIDTH(2)) u0 (
    .clk(clk), .reset(reset), .bus(if0), .cnt_clr(cnt_clr), .sat_cnt(c0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int scl(input longint p, input int sh, input bit rnd,
                             input bit sen, output bit s);
    longint v;
    v = p;
    s = 1'b0;
    if (rnd && sh > 0) v = v + (64'sd1 <<< (sh - 1));
    v = v >>> sh;
    if (sen) begin
      if (v > 16383) begin
        s = 1'b1;
        return 16383;
      end
      if (v < -16384) begin
        s = 1'b1;
        return -16384;
      end
      return int'(v);
    end
    v = v & 64'sd32767;
    if (v >= 16384) v = v - 32768;
    return int'(v);
  endfunction

  function automatic vec_t mk(input int a, input int b);
    vec_t   v;
    longint p;
    bit     s;
    p = longint'(a) * longint'(b);
    v.a = a;
    v.b = b;
    v.e_d = scl(p, 0, 1'b0, 1'b1, s);
    v.s_d = s;
    v.e_w = scl(p, 0, 1'b0, 1'b0, s);
    v.e_1 = scl(p, 4, 1'b1, 1'b1, s);
    v.s_1 = s;
    v.e_0 = scl(p, 4, 1'b0, 1'b1, s);
    v.s_0 = s;
    return v;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (reset) begin
      if (ifd.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("def_dout", $signed(ifd.dout), e.e_d);
          chk("def_sat", ifd.sat, e.s_d);
          chk("wrap_dout", $signed(ifw.dout), e.e_w);
          chk("wrap_sat", ifw.sat, 0);
          chk("rnd1_dout", $signed(if1.dout), e.e_1);
          chk("rnd1_sat", if1.sat, e.s_1);
          chk("rnd0_dout", $signed(if0.dout), e.e_0);
          chk("rnd0_sat", if0.sat, e.s_0);
        end
      end
      if (in_valid && ifd.in_ready) sb.push_back(cur);
    end
  end

  always @(negedge reset) sb.delete();

  task automatic send(input vec_t v);
    int n;
    n = 0;
    cur = v;
    din0 = v.a[14:0];
    din1 = v.b[14:0];
    in_valid = 1'b1;
    @(negedge clk);
    while (!ifd.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifd.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    tbl[0]  = '{100, 50, 5000, 1'b0, 5000, 313, 1'b0, 312, 1'b0};
    tbl[1]  = '{200, 200, 16383, 1'b1, 7232, 2500, 1'b0, 2500, 1'b0};
    tbl[2]  = '{-200, 200, -16384, 1'b1, -7232, -2500, 1'b0, -2500, 1'b0};
    tbl[3]  = '{3, 3, 9, 1'b0, 9, 1, 1'b0, 0, 1'b0};
    tbl[4]  = '{-3, 3, -9, 1'b0, -9, -1, 1'b0, -1, 1'b0};
    tbl[5]  = '{7, 5, 35, 1'b0, 35, 2, 1'b0, 2, 1'b0};
    tbl[6]  = '{-1, -1, 1, 1'b0, 1, 0, 1'b0, 0, 1'b0};
    tbl[7]  = '{16383, 1, 16383, 1'b0, 16383, 1024, 1'b0, 1023, 1'b0};
    tbl[8]  = '{-16384, 1, -16384, 1'b0, -16384, -1024, 1'b0, -1024, 1'b0};
    tbl[9]  = '{-16384, -16384, 16383, 1'b1, 0, 16383, 1'b1, 16383, 1'b1};
    tbl[10] = '{16383, 16383, 16383, 1'b1, 1, 16383, 1'b1, 16383, 1'b1};
    tbl[11] = '{-16384, 16383, -16384, 1'b1, -16384, -16384, 1'b1, -16384, 1'b1};
    tbl[12] = '{16383, -16384, -16384, 1'b1, -16384, -16384, 1'b1, -16384, 1'b1};

    reset = 1'b0;
    in_valid = 1'b0;
    din0 = '0;
    din1 = '0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    cur = tbl[0];

    #23;
    chk("rst_out_valid", ifd.out_valid, 0);
    chk("rst_dout", ifd.dout, 0);
    chk("rst_sat", ifd.sat, 0);
    chk("rst_sat_cnt", cd, 0);
    chk("rst_in_ready", ifd.in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge k, valid after edge k+3.
    cur = tbl[0];
    din0 = 15'd100;
    din1 = 15'd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_k1_valid", ifd.out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_k2_valid", ifd.out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_k3_valid", ifd.out_valid, 1);
    chk("lat_k3_dout", $signed(ifd.dout), 5000);
    drain();

    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();
    chk("cnt_def", cd, 6);
    chk("cnt_wrap", cw, 0);
    chk("cnt_rnd1_stick", c1, 3);
    chk("cnt_rnd0_stick", c0, 3);

    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_def", cd, 0);
    chk("clr_rnd1", c1, 0);

    // Saturated result held under backpressure, then clear vs increment.
    out_ready = 1'b0;
    send(mk(200, 200));
    n = 0;
    while (!ifd.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_valid", ifd.out_valid, 1);
    @(posedge clk);
    #1;
    chk("hold_dout", $signed(ifd.dout), 16383);
    chk("hold_sat", ifd.sat, 1);
    chk("hold_in_ready", ifd.in_ready, 0);
    chk("hold_cnt", cd, 0);
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_wins", cd, 0);
    drain();

    // Stream with a 3-cycle output stall in the middle.
    fork
      begin
        for (int i = 1; i <= 10; i++) send(mk(i, 2));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", ifd.in_ready, 0);
          chk("stall_valid", ifd.out_valid, 1);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    send(mk(200, 200));
    drain();
    chk("cnt_pre_rst", cd, 1);

    // Asynchronous reset with samples in flight.
    send(mk(5, 5));
    send(mk(6, 6));
    send(mk(7, 7));
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", ifd.out_valid, 0);
    chk("arst_cnt", cd, 0);
    chk("arst_dout", ifd.dout, 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", ifd.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(mk(-7, 9));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bgd_mul_pipe_sat.md
# bgd_mul_pipe_sat

Parametrised, pipelined signed multiplier with a valid/ready stream interface, fixed-point rescaling, selectable rounding, and optional saturation. It is the next-generation replacement for the fixed 15×15→15 ce-gated multipliers in the BGD datapath. It lets gradient/weight products be rescaled and clamped inside the multiplier instead of in downstream logic. It also counts saturation events for the training controller.

## Interface
Parameters:
- A_WIDTH, 15, signed width of din0
- B_WIDTH, 15, signed width of din1
- P_WIDTH, 15, signed width of dout
- FRAC_SHIFT, 0, arithmetic right shift applied to the full product, range 0..A_WIDTH+B_WIDTH-1
- ROUND_EN, 0
  - 1: round half up before the shift
  - 0: truncate toward −∞
- SAT_EN, 1
  - 1: saturate to the P_WIDTH signed range
  - 0: wrap, keeping the low P_WIDTH bits
- NUM_STAGE, 4, latency in cycles, minimum 3
- CNT_WIDTH, 16, width of the saturation counter

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  din0/din1 are valid
- in_ready  out  1  the block accepts input this cycle
- din0  in  A_WIDTH  signed operand A
- din1  in  B_WIDTH  signed operand B
- out_valid  out  1  dout/sat are valid
- out_ready  in  1  the consumer accepts output
- dout  out  P_WIDTH  signed scaled result
- sat  out  1  the result was clamped; always 0 when SAT_EN=0
- sat_cnt  out  CNT_WIDTH  count of saturated results delivered; sticks at all-ones
- cnt_clr  in  1  synchronous clear of sat_cnt

## Operation
- Pipeline stages:
  - S1: register the operands.
  - S2: full product, A_WIDTH+B_WIDTH bits, signed.
  - S3: round, shift, saturate/wrap.
  - S4..S(NUM_STAGE): pure delay registers.
  - Each stage carries a valid bit.
- Rounding (ROUND_EN=1, FRAC_SHIFT>0): add 2^(FRAC_SHIFT−1) to the full product, then shift arithmetically right by FRAC_SHIFT. Compute in A_WIDTH+B_WIDTH+1 bits so the addition cannot overflow.
- Truncation (ROUND_EN=0 or FRAC_SHIFT=0): arithmetic right shift only.
- Saturation (SAT_EN=1):
  - Scaled value > 2^(P_WIDTH−1)−1 → dout = 2^(P_WIDTH−1)−1, sat=1.
  - Scaled value < −2^(P_WIDTH−1) → dout = −2^(P_WIDTH−1), sat=1.
  - Otherwise dout is the exact value and sat=0.
- Wrap (SAT_EN=0): dout is the low P_WIDTH bits of the scaled value; sat=0.
- Flow control is a global stall: stall = out_valid & ~out_ready.
  - While stalled, every stage register and valid bit holds.
  - in_ready = ~stall (combinational from out_valid and out_ready).
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - A stage valid bit loads 0 when no input transfer occurs and the pipeline is not stalled (bubbles propagate).
- sat_cnt:
  - Increments by 1 on each output transfer with sat=1.
  - Holds at 2^CNT_WIDTH−1.
  - If cnt_clr is asserted in the same cycle as an increment, clear wins; the result is 0.

## Timing
- Reset (reset=0, asynchronous): all valid bits=0, out_valid=0, dout=0, sat=0, sat_cnt=0. in_ready=1 follows from out_valid=0. Data registers other than dout may also be cleared.
- Latency: a sample accepted on edge k appears with out_valid=1 after edge k+NUM_STAGE−1, i.e. NUM_STAGE cycles of register delay counting the input register, provided no stall occurs.
- Throughput: 1 sample/cycle while out_ready=1.
- Each stall cycle adds exactly 1 cycle of latency to every in-flight sample. Ordering is preserved, with no loss or duplication.
- dout/sat are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream discards all in-flight samples; nothing is emitted after release until new inputs arrive.
- Reset release is synchronised externally; there is no internal synchroniser.

## Test plan
- Defaults (15/15/15, shift 0, SAT_EN=1, NUM_STAGE=4): din0=100, din1=50 accepted at edge 0 → out_valid=1 after edge 3, dout=5000, sat=0.
- Saturation, defaults:
  - 200×200 → dout=16383, sat=1.
  - −200×200 → dout=−16384, sat=1.
  - sat_cnt=2 after both transfers.
  - cnt_clr pulsed → sat_cnt=0.
- Wrap, SAT_EN=0: 200×200 → dout=7232, sat=0, sat_cnt unchanged.
- Rounding, FRAC_SHIFT=4:
  - ROUND_EN=1: 3×3 → 1; −3×3 → −1; 7×5 → 2.
  - ROUND_EN=0: 3×3 → 0; −3×3 → −1; 7×5 → 2.
- Backpressure: stream operands 1..10 × 2 with out_ready low for 3 cycles mid-stream and in_valid held → outputs 2,4,…,20 in order, none lost or repeated; in_ready=0 during the stall.
- Reset mid-stream: drop reset with 3 samples in flight → out_valid=0 and sat_cnt=0 immediately (asynchronously); no stale output after release.
